// File: rtl/fir_stream_mac.sv
// fir_stream_mac: streaming FIR filter (delay line -> registered products -> rounded, saturated sum) with a valid/ready handshake on in_* and out_*, runtime coefficient writes (coef_we/addr/data; coef_err is sticky and flags an out-of-range address), and flush.
module fir_stream_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 32,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       coef_err,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_sat
);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;
  localparam int CW    = ACC_W > OUT_W ? ACC_W : OUT_W;
  localparam logic signed [ACC_W-1:0] RND  = SHIFT > 0 ? ACC_W'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  localparam logic signed [CW-1:0]    MAXV = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0]    MINV = ~MAXV;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_d [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic signed [PW-1:0]     p_q [TAPS];
  logic signed [PW-1:0]     p_d [TAPS];
  logic v0_q, v0_d, v1_q, v1_d, out_valid_q, out_valid_d;
  logic out_sat_q, out_sat_d, coef_err_q, coef_err_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic signed [ACC_W-1:0] sum, sh;
  logic signed [CW-1:0]    sx;
  logic en, acc, hi, lo;
  assign en        = !out_valid_q | out_ready;
  assign in_ready  = !rst & en & !flush;
  assign acc       = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign coef_err  = coef_err_q;
  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) sum = sum + ACC_W'(p_q[k]);
    sh = (sum + RND) >>> SHIFT;
    sx = CW'(sh);
    hi = sx > MAXV;
    lo = sx < MINV;
    x_d = x_q;
    coef_d = coef_q;
    p_d = p_q;
    v0_d = v0_q;
    v1_d = v1_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_sat_d = out_sat_q;
    for (int k = 0; k < TAPS; k++) coef_d[k] = coef_we && coef_addr == AW'(k) ? coef_data : coef_q[k];
    coef_err_d = coef_err_q | (coef_we & (32'(coef_addr) >= TAPS));
    if (acc) begin
      for (int k = TAPS - 1; k > 0; k--) x_d[k] = x_q[k-1];
      x_d[0] = in_data;
      v0_d = 1'b1;
    end else if (en) v0_d = 1'b0;
    if (en) begin
      for (int k = 0; k < TAPS; k++) p_d[k] = PW'(x_q[k]) * PW'(coef_q[k]);
      v1_d = v0_q;
      out_valid_d = v1_q;
      out_data_d = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : sx[OUT_W-1:0];
      out_sat_d = hi | lo;
    end
    if (flush) begin
      x_d = '{default: '0};
      v0_d = 1'b0;
      v1_d = 1'b0;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q <= '{default: '0};
      coef_q <= '{default: '0};
      p_q <= '{default: '0};
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      x_q <= x_d;
      coef_q <= coef_d;
      p_q <= p_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sat_q <= out_sat_d;
      coef_err_q <= coef_err_d;
    end
endmodule

// File: tb/tb_fir_stream_mac.sv
// tb_fir_stream_mac: table vectors plus randomized streaming against a queue-based FIR model
module tb_fir_stream_mac;
  logic clk = 1'b0, rst = 1'b1;
  logic a_coef_we = 1'b0, a_coef_err, a_flush = 1'b0, a_in_valid = 1'b0, a_in_ready;
  logic [1:0] a_coef_addr = '0;
  logic signed [15:0] a_coef_data = '0, a_in_data = '0;
  logic a_out_valid, a_out_ready = 1'b1, a_out_sat;
  logic signed [31:0] a_out_data;
  logic b_coef_we = 1'b0, b_coef_err, b_flush = 1'b0, b_in_valid = 1'b0, b_in_ready;
  logic [1:0] b_coef_addr = '0;
  logic signed [15:0] b_coef_data = '0, b_in_data = '0;
  logic b_out_valid, b_out_ready = 1'b1, b_out_sat;
  logic signed [15:0] b_out_data;
  fir_stream_mac #(.DATA_W(16), .COEF_W(16), .TAPS(4), .OUT_W(32), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .coef_we(a_coef_we), .coef_addr(a_coef_addr), .coef_data(a_coef_data),
    .coef_err(a_coef_err), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sat(a_out_sat));
  fir_stream_mac #(.DATA_W(16), .COEF_W(16), .TAPS(3), .OUT_W(16), .SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
    .coef_err(b_coef_err), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sat(b_out_sat));
  always #5 clk = ~clk;
  typedef struct {
    logic signed [15:0] din;
    longint             exp;
    logic               sat;
  } vec_t;
  vec_t vt [19];
  int pass_n = 0, total_n = 0;
  longint exp_q [$];
  longint hist [4];
  longint cf [4];
  task automatic chk(input string nm, input longint act, input longint exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input bit b, input int addr, input longint val);
    if (b) begin b_coef_we = 1'b1; b_coef_addr = 2'(addr); b_coef_data = 16'(val); end
    else begin a_coef_we = 1'b1; a_coef_addr = 2'(addr); a_coef_data = 16'(val); end
    step();
    a_coef_we = 1'b0;
    b_coef_we = 1'b0;
  endtask
  task automatic flush_it(input bit b);
    if (b) begin b_flush = 1'b1; b_in_valid = 1'b1; b_out_ready = 1'b1; end
    else begin a_flush = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1; end
    #1;
    chk("flush_in_ready", longint'(b ? b_in_ready : a_in_ready), 0);
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0;
    chk("flush_out_valid", longint'(b ? b_out_valid : a_out_valid), 0);
  endtask
  task automatic run_tbl(input bit b, input int lo, input int n);
    for (int j = 0; j < n + 2; j++) begin
      if (b) begin b_in_valid = j < n; b_in_data = j < n ? vt[lo+j].din : '0; end
      else begin a_in_valid = j < n; a_in_data = j < n ? vt[lo+j].din : '0; end
      step();
      if (j < 2) chk("tbl_latency", longint'(b ? b_out_valid : a_out_valid), 0);
      else begin
        chk("tbl_valid", longint'(b ? b_out_valid : a_out_valid), 1);
        chk("tbl_data", b ? longint'(b_out_data) : longint'(a_out_data), vt[lo+j-2].exp);
        chk("tbl_sat", longint'(b ? b_out_sat : a_out_sat), longint'(vt[lo+j-2].sat));
      end
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask
  initial begin
    int sent;
    bit prev_stall;
    longint prev_d, s;
    vt[0] = '{din: 1, exp: 1, sat: 0};
    vt[1] = '{din: 0, exp: 2, sat: 0};
    vt[2] = '{din: 0, exp: 3, sat: 0};
    vt[3] = '{din: 0, exp: 4, sat: 0};
    vt[4] = '{din: 0, exp: 0, sat: 0};
    vt[5] = '{din: 6, exp: 2, sat: 0};
    vt[6] = '{din: -6, exp: -1, sat: 0};
    vt[7] = '{din: 5, exp: 1, sat: 0};
    for (int i = 8; i < 11; i++) vt[i] = '{din: 32767, exp: 32767, sat: 1};
    for (int i = 11; i < 14; i++) vt[i] = '{din: 32767, exp: -32768, sat: 1};
    vt[14] = '{din: 1, exp: 0, sat: 0};
    for (int i = 15; i < 19; i++) vt[i] = '{din: 0, exp: 0, sat: 0};
    #2;
    chk("rst_out_valid", longint'(a_out_valid), 0);
    chk("rst_out_data", longint'(a_out_data), 0);
    chk("rst_out_sat", longint'(a_out_sat), 0);
    chk("rst_coef_err", longint'(a_coef_err), 0);
    chk("rst_in_ready", longint'(a_in_ready), 0);
    chk("rst_in_ready_b", longint'(b_in_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", longint'(a_in_ready), 1);
    step();
    load(1, 0, 1);
    run_tbl(1, 5, 3);
    load(1, 3, 77);
    chk("coef_err_set", longint'(b_coef_err), 1);
    flush_it(1);
    run_tbl(1, 5, 3);
    for (int k = 0; k < 3; k++) load(1, k, 32767);
    chk("coef_err_sticky", longint'(b_coef_err), 1);
    flush_it(1);
    run_tbl(1, 8, 3);
    for (int k = 0; k < 3; k++) load(1, k, -32768);
    flush_it(1);
    run_tbl(1, 11, 3);
    for (int k = 0; k < 4; k++) load(0, k, k + 1);
    run_tbl(0, 0, 5);
    for (int k = 0; k < 4; k++) begin
      cf[k] = longint'($urandom_range(0, 2000)) - 1000;
      load(0, k, cf[k]);
      hist[k] = 0;
    end
    flush_it(0);
    sent = 0;
    prev_stall = 1'b0;
    prev_d = 0;
    for (int c = 0; c < 2000 && (sent < 80 || exp_q.size() > 0); c++) begin
      a_in_valid = sent < 80 && $urandom_range(0, 3) != 0;
      a_in_data = sent < 20 ? 16'(sent + 1) : 16'($urandom);
      a_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_valid", longint'(a_out_valid), 1);
        chk("stall_data", longint'(a_out_data), prev_d);
      end
      if (a_out_valid && a_out_ready) begin
        if (exp_q.size() == 0) begin
          total_n++;
          $display("FAIL stream_extra: got %0d, expected no pending output", a_out_data);
        end else chk("stream_data", longint'(a_out_data), exp_q.pop_front());
      end
      if (a_in_valid && a_in_ready) begin
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'(a_in_data);
        s = 0;
        for (int k = 0; k < 4; k++) s += hist[k] * cf[k];
        exp_q.push_back(s);
        sent++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_d = longint'(a_out_data);
      step();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    chk("stream_sent", longint'(sent), 80);
    chk("stream_drained", longint'(exp_q.size()), 0);
    for (int k = 0; k < 4; k++) load(0, k, k + 1);
    a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = 16'(100 * (i + 1));
      step();
    end
    chk("pre_flush_valid", longint'(a_out_valid), 1);
    flush_it(0);
    run_tbl(0, 0, 5);
    a_in_valid = 1'b1;
    a_in_data = 16'(7);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", longint'(a_out_valid), 0);
    chk("midrst_in_ready", longint'(a_in_ready), 0);
    chk("midrst_coef_err", longint'(b_coef_err), 0);
    a_in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    run_tbl(0, 14, 5);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
